// File: rtl/dm_port_arbiter_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
// Covers the FSM state encoding and byte-write-enable decode.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_RESP = 2'd1,
        DMA_RESP = 2'd2
    } dm_arb_state_t;

    localparam logic [3:0] WEB_NONE = 4'b1111;

    function automatic logic is_read(input logic [3:0] web);
        return web == WEB_NONE;
    endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bundles the MEM-stage, DMA and SRAM-macro pins of the data-memory arbiter.
// slave = arbiter view, master = surrounding logic (pipeline, DMA, SRAM).
interface dm_port_arbiter_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic [3:0]            mem_web;
    logic [31:0]           mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_stall;

    logic                  dma_valid;
    logic                  dma_ready;
    logic [3:0]            dma_web;
    logic [31:0]           dma_addr;
    logic [DATA_WIDTH-1:0] dma_wdata;
    logic                  dma_rvalid;
    logic [DATA_WIDTH-1:0] dma_rdata;

    logic                  sram_cs;
    logic [3:0]            sram_web;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_di;
    logic [DATA_WIDTH-1:0] sram_do;

    modport slave (
        input  mem_req, mem_web, mem_addr, mem_wdata,
        output mem_rdata, mem_stall,
        input  dma_valid, dma_web, dma_addr, dma_wdata,
        output dma_ready, dma_rvalid, dma_rdata,
        output sram_cs, sram_web, sram_addr, sram_di,
        input  sram_do
    );

    modport master (
        output mem_req, mem_web, mem_addr, mem_wdata,
        input  mem_rdata, mem_stall,
        output dma_valid, dma_web, dma_addr, dma_wdata,
        input  dma_ready, dma_rvalid, dma_rdata,
        input  sram_cs, sram_web, sram_addr, sram_di,
        output sram_do
    );

endinterface

// File: rtl/dm_port_arbiter_starve.sv
// Saturating count of consecutive cycles the DMA port was left waiting.
// at_limit forces the next IDLE grant to the DMA port.
module dm_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);
    localparam logic [3:0] LIM = 4'(LIMIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (inc && (cnt_q != LIM)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LIM);

endmodule

// File: rtl/dm_port_arbiter.sv
// Arbitrates the single-port data SRAM between the MEM stage (priority) and a DMA port.
// Reads return one cycle after issue; a starvation counter guarantees DMA progress.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   IDLE     | grant/issue; at most one SRAM access per cycle
//   MEM_RESP | MEM load data on sram_do, no issue
//   DMA_RESP | DMA read data on sram_do, no issue
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           rst,
    dm_port_arbiter_if.slave bus
);

    dm_arb_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] di_q, di_d;
    logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
    logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;

    logic                  at_limit;
    logic                  dma_win;
    logic                  cs;
    logic [3:0]            web;
    logic                  dma_ready;
    logic                  dma_rvalid;
    logic                  mem_stall;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] dma_rdata;

    dm_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (bus.dma_valid & ~dma_ready),
        .clr      (~bus.dma_valid | dma_ready),
        .at_limit (at_limit)
    );

    assign dma_win = bus.dma_valid & (~bus.mem_req | at_limit);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        di_d        = di_q;
        mem_rdata_d = mem_rdata_q;
        dma_rdata_d = dma_rdata_q;
        cs          = 1'b0;
        web         = WEB_NONE;
        dma_ready   = 1'b0;
        dma_rvalid  = 1'b0;
        mem_stall   = 1'b0;
        mem_rdata   = mem_rdata_q;
        dma_rdata   = dma_rdata_q;

        case (state_q)
            IDLE: begin
                if (dma_win) begin
                    cs        = 1'b1;
                    web       = bus.dma_web;
                    addr_d    = bus.dma_addr[ADDR_WIDTH+1:2];
                    di_d      = bus.dma_wdata;
                    dma_ready = 1'b1;
                    mem_stall = bus.mem_req;
                    if (is_read(bus.dma_web)) begin
                        state_d = DMA_RESP;
                    end
                end else if (bus.mem_req) begin
                    cs     = 1'b1;
                    web    = bus.mem_web;
                    addr_d = bus.mem_addr[ADDR_WIDTH+1:2];
                    di_d   = bus.mem_wdata;
                    if (is_read(bus.mem_web)) begin
                        mem_stall = 1'b1;
                        state_d   = MEM_RESP;
                    end
                end
            end
            // The load that caused MEM_RESP is still presented; it completes here.
            MEM_RESP: begin
                mem_rdata   = bus.sram_do;
                mem_rdata_d = bus.sram_do;
                state_d     = IDLE;
            end
            DMA_RESP: begin
                dma_rvalid  = 1'b1;
                dma_rdata   = bus.sram_do;
                dma_rdata_d = bus.sram_do;
                mem_stall   = bus.mem_req;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset is synchronous, so quiet the pins during the reset cycle itself too.
        if (rst) begin
            cs         = 1'b0;
            web        = WEB_NONE;
            dma_ready  = 1'b0;
            dma_rvalid = 1'b0;
            mem_stall  = 1'b0;
            mem_rdata  = '0;
            dma_rdata  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            di_q        <= '0;
            mem_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            di_q        <= di_d;
            mem_rdata_q <= mem_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign bus.sram_cs    = cs;
    assign bus.sram_web   = web;
    assign bus.sram_addr  = addr_d;
    assign bus.sram_di    = di_d;
    assign bus.dma_ready  = dma_ready;
    assign bus.dma_rvalid = dma_rvalid;
    assign bus.dma_rdata  = dma_rdata;
    assign bus.mem_stall  = mem_stall;
    assign bus.mem_rdata  = mem_rdata;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.mem_addr[1:0], bus.mem_addr[31:ADDR_WIDTH+2],
                                bus.dma_addr[1:0], bus.dma_addr[31:ADDR_WIDTH+2]};

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter with a behavioural byte-lane SRAM.
// Expected read data comes from a reference memory and is queued at issue time.
module tb_dm_port_arbiter;
    import dm_arb_pkg::*;

    localparam int AW = 14;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dm_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dm_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] sram    [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];
    logic [31:0] do_q;
    logic [31:0] mem_q[$];
    logic [31:0] dma_q[$];
    logic [31:0] exp_w;
    logic [31:0] last_mem;
    logic [31:0] last_dma;
    int          j;

    always @(posedge clk) begin
        if (bus.sram_cs) begin
            for (int b = 0; b < 4; b++) begin
                if (!bus.sram_web[b]) sram[bus.sram_addr][8*b +: 8] <= bus.sram_di[8*b +: 8];
            end
            if (bus.sram_web == 4'b1111) do_q <= sram[bus.sram_addr];
        end
    end
    assign bus.sram_do = do_q;

    function automatic logic [AW-1:0] waddr(input logic [31:0] a);
        return a[AW+1:2];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] web);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (!web[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic mem_drive(input logic req, input logic [3:0] web, input logic [31:0] addr,
                             input logic [31:0] wdata);
        bus.mem_req = req; bus.mem_web = web; bus.mem_addr = addr; bus.mem_wdata = wdata;
    endtask

    task automatic dma_drive(input logic valid, input logic [3:0] web, input logic [31:0] addr,
                             input logic [31:0] wdata);
        bus.dma_valid = valid; bus.dma_web = web; bus.dma_addr = addr; bus.dma_wdata = wdata;
    endtask

    task automatic idle_inputs();
        mem_drive(1'b0, WEB_NONE, 32'h0, 32'h0);
        dma_drive(1'b0, WEB_NONE, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_drive(1'b1, WEB_NONE, 32'h100, 32'h0);
        dma_drive(1'b1, WEB_NONE, 32'h200, 32'h0);
        cyc(); samp();
        vectors++; if (bus.sram_cs !== 1'b0) begin miscompares++; $display("FAIL rst_cs: got %b want 0", bus.sram_cs); end
        vectors++; if (bus.sram_web !== 4'hF) begin miscompares++; $display("FAIL rst_web: got %h want f", bus.sram_web); end
        vectors++; if (bus.dma_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b want 0", bus.dma_ready); end
        vectors++; if (bus.dma_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid: got %b want 0", bus.dma_rvalid); end
        vectors++; if (bus.mem_stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %b want 0", bus.mem_stall); end
        cyc(); samp();
        vectors++; if (bus.mem_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_mem_rdata: got %h want 0", bus.mem_rdata); end
        vectors++; if (bus.dma_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_dma_rdata: got %h want 0", bus.dma_rdata); end
        cyc(); rst = 1'b0; idle_inputs(); samp();
        vectors++; if (bus.sram_cs !== 1'b0) begin miscompares++; $display("FAIL post_rst_cs: got %b want 0", bus.sram_cs); end
    endtask

    task automatic test_mem_store();
        cyc(); mem_drive(1'b1, 4'b0000, 32'h100, 32'hDEADBEEF); samp();
        vectors++; if (bus.sram_cs !== 1'b1) begin miscompares++; $display("FAIL sw_cs: got %b want 1", bus.sram_cs); end
        vectors++; if (bus.sram_addr !== 14'h040) begin miscompares++; $display("FAIL sw_addr: got %h want 040", bus.sram_addr); end
        vectors++; if (bus.sram_web !== 4'h0) begin miscompares++; $display("FAIL sw_web: got %h want 0", bus.sram_web); end
        vectors++; if (bus.sram_di !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sw_di: got %h want deadbeef", bus.sram_di); end
        vectors++; if (bus.mem_stall !== 1'b0) begin miscompares++; $display("FAIL sw_stall: got %b want 0", bus.mem_stall); end
        ref_mem[waddr(32'h100)] = merge(ref_mem[waddr(32'h100)], 32'hDEADBEEF, 4'b0000);
        cyc(); idle_inputs(); samp();
        vectors++; if (bus.sram_cs !== 1'b0) begin miscompares++; $display("FAIL idle_cs: got %b want 0", bus.sram_cs); end
        vectors++; if (bus.sram_web !== 4'hF) begin miscompares++; $display("FAIL idle_web: got %h want f", bus.sram_web); end
        vectors++; if (bus.sram_addr !== 14'h040) begin miscompares++; $display("FAIL idle_addr_hold: got %h want 040", bus.sram_addr); end
        vectors++; if (bus.sram_di !== 32'hDEADBEEF) begin miscompares++; $display("FAIL idle_di_hold: got %h want deadbeef", bus.sram_di); end
    endtask

    task automatic test_mem_load();
        logic [31:0] addrs [2];
        addrs[0] = 32'h0000_0100;
        addrs[1] = 32'hABCD_0102;
        for (int i = 0; i < 2; i++) begin
            cyc(); mem_drive(1'b1, WEB_NONE, addrs[i], 32'h0);
            mem_q.push_back(ref_mem[waddr(addrs[i])]); samp();
            vectors++; if (bus.mem_stall !== 1'b1) begin miscompares++; $display("FAIL lw_issue_stall: got %b want 1", bus.mem_stall); end
            vectors++; if (bus.sram_addr !== 14'h040) begin miscompares++; $display("FAIL lw_addr: got %h want 040", bus.sram_addr); end
            vectors++; if (bus.sram_web !== 4'hF) begin miscompares++; $display("FAIL lw_web: got %h want f", bus.sram_web); end
            cyc(); samp();
            exp_w = mem_q.pop_front();
            vectors++; if (bus.mem_stall !== 1'b0) begin miscompares++; $display("FAIL lw_resp_stall: got %b want 0", bus.mem_stall); end
            vectors++; if (bus.sram_cs !== 1'b0) begin miscompares++; $display("FAIL lw_resp_cs: got %b want 0", bus.sram_cs); end
            vectors++; if (bus.mem_rdata !== exp_w) begin miscompares++; $display("FAIL lw_rdata: got %h want %h", bus.mem_rdata, exp_w); end
            last_mem = exp_w;
        end
        cyc(); idle_inputs(); samp();
        vectors++; if (bus.mem_rdata !== last_mem) begin miscompares++; $display("FAIL lw_hold: got %h want %h", bus.mem_rdata, last_mem); end
    endtask

    task automatic test_dma_read();
        cyc(); dma_drive(1'b1, WEB_NONE, 32'h100, 32'h0);
        dma_q.push_back(ref_mem[waddr(32'h100)]); samp();
        vectors++; if (bus.dma_ready !== 1'b1) begin miscompares++; $display("FAIL dr_ready: got %b want 1", bus.dma_ready); end
        vectors++; if (bus.dma_rvalid !== 1'b0) begin miscompares++; $display("FAIL dr_early_rvalid: got %b want 0", bus.dma_rvalid); end
        cyc(); idle_inputs(); samp();
        exp_w = dma_q.pop_front();
        vectors++; if (bus.dma_rvalid !== 1'b1) begin miscompares++; $display("FAIL dr_rvalid: got %b want 1", bus.dma_rvalid); end
        vectors++; if (bus.dma_rdata !== exp_w) begin miscompares++; $display("FAIL dr_rdata: got %h want %h", bus.dma_rdata, exp_w); end
        last_dma = exp_w;
        cyc(); samp();
        vectors++; if (bus.dma_rvalid !== 1'b0) begin miscompares++; $display("FAIL dr_pulse: got %b want 0", bus.dma_rvalid); end
        vectors++; if (bus.dma_rdata !== last_dma) begin miscompares++; $display("FAIL dr_hold: got %h want %h", bus.dma_rdata, last_dma); end
    endtask

    // Stores held back-to-back against a waiting DMA write; DMA must win every 5th cycle.
    task automatic test_starvation();
        logic [31:0] ma, da;
        for (int r = 0; r < 2; r++) begin
            da = 32'h300 + 32'(4 * r);
            for (int k = 0; k < 5; k++) begin
                ma = 32'h200 + 32'(4 * j);
                cyc();
                mem_drive(1'b1, 4'b0000, ma, 32'hA000_0000 + 32'(j));
                dma_drive(1'b1, 4'b0000, da, 32'h5A5A_0000 + 32'(r));
                samp();
                if (k < 4) begin
                    vectors++; if (bus.dma_ready !== 1'b0) begin miscompares++; $display("FAIL stv_blocked r%0d k%0d: got %b want 0", r, k, bus.dma_ready); end
                    vectors++; if (bus.mem_stall !== 1'b0) begin miscompares++; $display("FAIL stv_mem_stall r%0d k%0d: got %b want 0", r, k, bus.mem_stall); end
                    vectors++; if (bus.sram_addr !== waddr(ma)) begin miscompares++; $display("FAIL stv_mem_addr: got %h want %h", bus.sram_addr, waddr(ma)); end
                    ref_mem[waddr(ma)] = merge(ref_mem[waddr(ma)], 32'hA000_0000 + 32'(j), 4'b0000);
                    j++;
                end else begin
                    vectors++; if (bus.dma_ready !== 1'b1) begin miscompares++; $display("FAIL stv_grant r%0d: got %b want 1", r, bus.dma_ready); end
                    vectors++; if (bus.mem_stall !== 1'b1) begin miscompares++; $display("FAIL stv_grant_stall r%0d: got %b want 1", r, bus.mem_stall); end
                    vectors++; if (bus.sram_addr !== waddr(da)) begin miscompares++; $display("FAIL stv_dma_addr: got %h want %h", bus.sram_addr, waddr(da)); end
                    ref_mem[waddr(da)] = merge(ref_mem[waddr(da)], 32'h5A5A_0000 + 32'(r), 4'b0000);
                end
            end
        end
        cyc(); idle_inputs();
    endtask

    // Dropping dma_valid for one cycle must restart the starvation count.
    task automatic test_starve_clear();
        logic [31:0] ma;
        logic        want_ready;
        for (int c = 0; c < 9; c++) begin
            ma = 32'h200 + 32'(4 * j);
            want_ready = (c == 8);
            cyc();
            mem_drive(1'b1, 4'b0000, ma, 32'hA000_0000 + 32'(j));
            dma_drive(c != 3, 4'b0000, 32'h308, 32'h7777_0000);
            samp();
            vectors++; if (bus.dma_ready !== want_ready) begin miscompares++; $display("FAIL clr_ready c%0d: got %b want %b", c, bus.dma_ready, want_ready); end
            if (want_ready) begin
                ref_mem[waddr(32'h308)] = merge(ref_mem[waddr(32'h308)], 32'h7777_0000, 4'b0000);
            end else begin
                ref_mem[waddr(ma)] = merge(ref_mem[waddr(ma)], 32'hA000_0000 + 32'(j), 4'b0000);
                j++;
            end
        end
        cyc(); idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [31:0] la [6];
        la[0] = 32'h200; la[1] = 32'h204; la[2] = 32'h20C;
        la[3] = 32'h300; la[4] = 32'h304; la[5] = 32'h308;
        for (int i = 0; i < 6; i++) begin
            cyc(); mem_drive(1'b1, WEB_NONE, la[i], 32'h0);
            mem_q.push_back(ref_mem[waddr(la[i])]); samp();
            vectors++; if (bus.mem_stall !== 1'b1) begin miscompares++; $display("FAIL b2b_issue_stall %0d: got %b want 1", i, bus.mem_stall); end
            cyc(); samp();
            exp_w = mem_q.pop_front();
            vectors++; if (bus.mem_stall !== 1'b0) begin miscompares++; $display("FAIL b2b_resp_stall %0d: got %b want 0", i, bus.mem_stall); end
            vectors++; if (bus.mem_rdata !== exp_w) begin miscompares++; $display("FAIL b2b_rdata %0d: got %h want %h", i, bus.mem_rdata, exp_w); end
        end
        cyc(); idle_inputs();
    endtask

    task automatic test_dma_write_lane();
        cyc(); mem_drive(1'b1, 4'b0000, 32'h104, 32'hCAFEF00D);
        ref_mem[waddr(32'h104)] = 32'hCAFEF00D;
        cyc(); mem_drive(1'b0, WEB_NONE, 32'h0, 32'h0);
        dma_drive(1'b1, WEB_NONE, 32'h100, 32'h0);
        dma_q.push_back(ref_mem[waddr(32'h100)]); samp();
        vectors++; if (bus.dma_ready !== 1'b1) begin miscompares++; $display("FAIL dw_rd_ready: got %b want 1", bus.dma_ready); end
        cyc(); mem_drive(1'b1, WEB_NONE, 32'h104, 32'h0);
        dma_drive(1'b1, 4'b1110, 32'h104, 32'h1111_11AB); samp();
        exp_w = dma_q.pop_front();
        vectors++; if (bus.dma_rdata !== exp_w) begin miscompares++; $display("FAIL dw_rd_data: got %h want %h", bus.dma_rdata, exp_w); end
        vectors++; if (bus.mem_stall !== 1'b1) begin miscompares++; $display("FAIL dw_dresp_stall: got %b want 1", bus.mem_stall); end
        vectors++; if (bus.sram_cs !== 1'b0) begin miscompares++; $display("FAIL dw_dresp_cs: got %b want 0", bus.sram_cs); end
        vectors++; if (bus.dma_ready !== 1'b0) begin miscompares++; $display("FAIL dw_dresp_ready: got %b want 0", bus.dma_ready); end
        cyc(); mem_q.push_back(ref_mem[waddr(32'h104)]); samp();
        vectors++; if (bus.mem_stall !== 1'b1) begin miscompares++; $display("FAIL dw_lw_stall: got %b want 1", bus.mem_stall); end
        vectors++; if (bus.dma_ready !== 1'b0) begin miscompares++; $display("FAIL dw_mem_prio: got %b want 0", bus.dma_ready); end
        cyc(); samp();
        exp_w = mem_q.pop_front();
        vectors++; if (bus.mem_rdata !== exp_w) begin miscompares++; $display("FAIL dw_lw_data: got %h want %h", bus.mem_rdata, exp_w); end
        cyc(); mem_drive(1'b0, WEB_NONE, 32'h0, 32'h0); samp();
        vectors++; if (bus.dma_ready !== 1'b1) begin miscompares++; $display("FAIL dw_wr_ready: got %b want 1", bus.dma_ready); end
        vectors++; if (bus.sram_web !== 4'b1110) begin miscompares++; $display("FAIL dw_wr_web: got %h want e", bus.sram_web); end
        ref_mem[waddr(32'h104)] = merge(ref_mem[waddr(32'h104)], 32'h1111_11AB, 4'b1110);
        cyc(); dma_drive(1'b0, WEB_NONE, 32'h0, 32'h0);
        mem_drive(1'b1, WEB_NONE, 32'h104, 32'h0);
        mem_q.push_back(ref_mem[waddr(32'h104)]);
        cyc(); samp();
        exp_w = mem_q.pop_front();
        vectors++; if (bus.mem_rdata !== exp_w) begin miscompares++; $display("FAIL dw_lane0: got %h want %h", bus.mem_rdata, exp_w); end
        cyc(); idle_inputs();
    endtask

    task automatic test_reset_midread();
        cyc(); mem_drive(1'b1, WEB_NONE, 32'h104, 32'h0);
        cyc(); rst = 1'b1; samp();
        vectors++; if (bus.sram_cs !== 1'b0) begin miscompares++; $display("FAIL rmr_cs: got %b want 0", bus.sram_cs); end
        vectors++; if (bus.mem_stall !== 1'b0) begin miscompares++; $display("FAIL rmr_stall: got %b want 0", bus.mem_stall); end
        cyc(); rst = 1'b0; idle_inputs(); samp();
        vectors++; if (bus.mem_rdata !== 32'h0) begin miscompares++; $display("FAIL rmr_rdata: got %h want 0", bus.mem_rdata); end
        vectors++; if (bus.sram_web !== 4'hF) begin miscompares++; $display("FAIL rmr_web: got %h want f", bus.sram_web); end
        cyc(); dma_drive(1'b1, WEB_NONE, 32'h100, 32'h0); samp();
        vectors++; if (bus.dma_ready !== 1'b1) begin miscompares++; $display("FAIL rdr_ready: got %b want 1", bus.dma_ready); end
        cyc(); rst = 1'b1; dma_drive(1'b0, WEB_NONE, 32'h0, 32'h0); samp();
        vectors++; if (bus.dma_rvalid !== 1'b0) begin miscompares++; $display("FAIL rdr_rvalid: got %b want 0", bus.dma_rvalid); end
        cyc(); rst = 1'b0; mem_drive(1'b1, 4'b0000, 32'h108, 32'h0BAD_CAFE); samp();
        vectors++; if (bus.dma_rvalid !== 1'b0) begin miscompares++; $display("FAIL rdr_rvalid_after: got %b want 0", bus.dma_rvalid); end
        vectors++; if (bus.dma_rdata !== 32'h0) begin miscompares++; $display("FAIL rdr_rdata: got %h want 0", bus.dma_rdata); end
        vectors++; if (bus.sram_cs !== 1'b1) begin miscompares++; $display("FAIL rdr_idle_issue: got %b want 1", bus.sram_cs); end
        ref_mem[waddr(32'h108)] = 32'h0BAD_CAFE;
        cyc(); mem_drive(1'b1, WEB_NONE, 32'h108, 32'h0);
        mem_q.push_back(ref_mem[waddr(32'h108)]);
        cyc(); samp();
        exp_w = mem_q.pop_front();
        vectors++; if (bus.mem_rdata !== exp_w) begin miscompares++; $display("FAIL rdr_readback: got %h want %h", bus.mem_rdata, exp_w); end
        cyc(); idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        do_q = 32'h0;
        j    = 0;
        rst  = 1'b1;
        idle_inputs();
        test_reset();
        test_mem_store();
        test_mem_load();
        test_dma_read();
        test_starvation();
        test_starve_clear();
        test_back_to_back();
        test_dma_write_lane();
        test_reset_midread();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
